// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine (MSB first, init 0, no reflection, no final XOR).
// Bytes are accepted on a valid/ready handshake and the message CRC is held until taken.
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] crc_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  sreg_q, sreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        last_q, last_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        fb;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    crc_d     = crc_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    fb        = crc_q[7] ^ sreg_q[7];

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sreg_d    = in_data;
          last_d    = in_last;
          bit_cnt_d = 3'd0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        crc_d     = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        sreg_d    = {sreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = last_q ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        // Taking the result also starts the next message from a clean accumulator.
        if (out_ready) begin
          crc_d   = 8'h00;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered from the next state so they align with it.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= 8'h00;
      sreg_q      <= 8'h00;
      bit_cnt_q   <= 3'd0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign crc_out   = crc_q;

endmodule

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial: directed scenarios plus random messages
// compared against a byte-wise CRC-8 reference model.
module tb_crc8_serial;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] crc_out;
  logic       busy;

  int check_cnt = 0;
  int pass_cnt  = 0;

  crc8_serial #(.POLY(8'h07)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .crc_out   (crc_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Textbook byte-at-a-time CRC-8: fold the byte in, then eight polynomial divisions.
  function automatic logic [7:0] crc_model(input byte_q_t msg);
    logic [7:0] c = 8'h00;
    foreach (msg[i]) begin
      c = c ^ msg[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Sends one message and consumes its result. hold keeps in_valid high between bytes,
  // stall delays out_ready in DONE, early_rdy drives out_ready while no result is pending.
  task automatic run_msg(input string name, input byte_q_t msg, input bit hold,
                         input int stall, input bit early_rdy, input bit has_exp,
                         input logic [7:0] exp_fixed);
    logic [7:0] exp;
    logic [7:0] held;
    int cnt;
    exp = has_exp ? exp_fixed : crc_model(msg);
    for (int i = 0; i < msg.size(); i++) begin
      bit last = (i == msg.size() - 1);
      in_valid  = 1'b1;
      in_data   = msg[i];
      in_last   = last;
      out_ready = early_rdy && !last;
      cnt = 0;
      while (!in_ready && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 50) check({name, "_accept_timeout"}, cnt, 0);
      @(negedge clk);
      if (!hold || last) in_valid = 1'b0;
      if (last) out_ready = 1'b0;
      if (!last) begin
        cnt = 0;
        while (!in_ready && cnt < 20) begin
          cnt++;
          @(negedge clk);
        end
        check({name, "_ready_gap"}, cnt, 8);
      end else begin
        cnt = 0;
        while (!out_valid && cnt < 50) begin
          @(negedge clk);
          cnt++;
        end
        // Eight edges after the accepting edge: nine cycles acceptance-to-result.
        check({name, "_latency"}, cnt, 8);
      end
    end
    check({name, "_crc"}, crc_out, exp);
    check({name, "_busy_done"}, busy, 1'b1);
    check({name, "_in_ready_done"}, in_ready, 1'b0);
    held = crc_out;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({name, "_stall_valid"}, out_valid, 1'b1);
      check({name, "_stall_crc"}, crc_out, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_taken_valid"}, out_valid, 1'b0);
    check({name, "_taken_in_ready"}, {in_ready, busy}, 2'b10);
    check({name, "_taken_crc_clr"}, crc_out, 8'h00);
  endtask

  initial begin
    byte_q_t m;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {in_ready, out_valid, busy, crc_out}, {3'b100, 8'h00});
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready_noeffect", {in_ready, out_valid, busy}, 3'b100);

    m = {8'h01}; run_msg("b01", m, 0, 0, 0, 1, 8'h07);
    m = {8'hFF}; run_msg("bFF", m, 0, 0, 0, 1, 8'hF3);
    m = {8'h80}; run_msg("b80", m, 0, 0, 0, 1, 8'h89);
    m = {8'h00}; run_msg("b00", m, 0, 0, 0, 1, 8'h00);
    m = {8'h01, 8'h02}; run_msg("two_byte", m, 0, 0, 1, 1, 8'h1B);
    m = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_msg("ascii_check", m, 1, 0, 0, 1, 8'hF4);
    m = {8'hA5, 8'h3C}; run_msg("backpressure", m, 0, 20, 0, 0, 8'h00);
    m = {8'h01}; run_msg("after_bp", m, 0, 0, 0, 1, 8'h07);

    // Reset in mid-SHIFT (bit_cnt==4) with a byte offered on the reset edge.
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_outputs", {in_ready, out_valid, busy, crc_out}, {3'b100, 8'h00});
    @(negedge clk);
    check("rst_discards_offer", {in_ready, busy}, 2'b10);
    m = {8'h01}; run_msg("after_rst", m, 0, 0, 0, 1, 8'h07);

    for (int t = 0; t < 12; t++) begin
      int len = $urandom_range(1, 5);
      m = {};
      for (int k = 0; k < len; k++) m.push_back(8'($urandom));
      run_msg($sformatf("rand%0d", t), m, 1'($urandom), $urandom_range(0, 4),
              1'($urandom), 0, 8'h00);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
